// File: rtl/data_memory_ctrl.sv
// Multi-cycle data memory with valid/ready request/response handshake; contents preset to mem[i] = i on reset.
// Latency: response valid WAIT_CYCLES+1 cycles after the accept edge; optional byte strobes under DMEM_BYTE_STROBE_EN.
// Backpressure: one transaction in flight; req_ready low until the response is taken, response held while resp_ready low.
module data_memory_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 2**ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_error,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 4;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W-1:0]   wmask;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                accept;
    logic                access;
    logic                resp_done;
    logic                addr_err;
    logic                mem_we;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && req_valid;
    assign access    = (state == WAIT) && (cnt == '0);
    assign resp_done = (state == RESP) && resp_ready;
    assign addr_err  = ({1'b0, lat_addr} >= DEPTH_L);
    assign mem_we    = access && lat_write && !addr_err;

`ifdef DMEM_BYTE_STROBE_EN
    logic [STRB_W-1:0] lat_wstrb;

    always_comb begin
        wmask = '0;
        for (int k = 0; k < STRB_W; k++) begin
            wmask[8*k +: 8] = {8{lat_wstrb[k]}};
        end
    end
`else
    // Full-word writes: strobes are accepted on the port but carry no meaning.
    logic unused_wstrb;
    assign unused_wstrb = ^req_wstrb;
    assign wmask        = '1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid)  state_nxt = WAIT;
            WAIT:    if (cnt == '0)  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, wait-state counter and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
`ifdef DMEM_BYTE_STROBE_EN
            lat_wstrb  <= '0;
`endif
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
                lat_wstrb <= req_wstrb;
`endif
                cnt       <= CNT_W'(WAIT_CYCLES);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (access) begin
                resp_valid <= 1'b1;
                resp_error <= addr_err;
                resp_rdata <= (!lat_write && !addr_err) ? rd_word : '0;
            end else if (resp_done) begin
                resp_valid <= 1'b0;
                resp_rdata <= '0;
                resp_error <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (lat_addr == ADDR_W'(i)) begin
                rd_word = mem[i];
            end
        end
    end

    // Storage resets to its own index so pipeline tests find known data without a loader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (mem_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lat_addr == ADDR_W'(i)) begin
                    mem[i] <= (mem[i] & ~wmask) | (lat_wdata & wmask);
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: three controllers (WAIT_CYCLES 2, 0, 15; DEPTH 48) driven by one request stream.
// Expected responses and accept cycles are queued at accept time and checked as each controller responds.
module tb_data_memory_ctrl;

    localparam int NDUT  = 3;
    localparam int DEPTH = 48;
    localparam int LAT [NDUT] = '{3, 1, 16};

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [5:0]  req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_ready = 1'b1;

    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] rv;
    logic [NDUT-1:0] re;
    logic [NDUT-1:0] bsy;
    logic [31:0]     rd [NDUT];

    exp_t        sb_q [NDUT][$];
    logic [31:0] mdl [64];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(6), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(rv[0]),
        .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_error(re[0]), .busy(bsy[0]));

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(6), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(rv[1]),
        .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_error(re[1]), .busy(bsy[1]));

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(6), .DEPTH(DEPTH), .WAIT_CYCLES(15)) u_dut_w15 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(rv[2]),
        .resp_ready(resp_ready), .resp_rdata(rd[2]), .resp_error(re[2]), .busy(bsy[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 32'(i);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s_u%0d_req_ready", tag, g), 32'(rdy[g]), 1);
            check($sformatf("%s_u%0d_busy", tag, g), 32'(bsy[g]), 0);
            check($sformatf("%s_u%0d_resp_valid", tag, g), 32'(rv[g]), 0);
            check($sformatf("%s_u%0d_resp_rdata", tag, g), rd[g], 0);
            check($sformatf("%s_u%0d_resp_error", tag, g), 32'(re[g]), 0);
        end
    endtask

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_addr  = 6'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    // Present a request, wait for the accept edge and queue the expected response.
    task automatic do_req(input logic w, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic push);
        exp_t e;
        bit   ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (&rdy) begin ok = 1'b1; break; end
        end
        check("accept_timeout", 32'(ok), 1);
        e.acc = 32'(cyc + 1);
        e.rdata = '0;
        e.err = 1'b0;
        if (int'(a) >= DEPTH) begin
            e.err = 1'b1;
        end else if (!w) begin
            e.rdata = mdl[a];
        end else if (push) begin
`ifdef DMEM_BYTE_STROBE_EN
            for (int k = 0; k < 4; k++) if (s[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
`else
            mdl[a] = d;
`endif
        end
        if (push) for (int g = 0; g < NDUT; g++) sb_q[g].push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bsy == '0 && sb_q[0].size() == 0 && sb_q[1].size() == 0 && sb_q[2].size() == 0) return;
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic txn(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        do_req(w, a, d, s, 1'b1);
        wait_idle();
    endtask

    for (genvar g = 0; g < NDUT; g++) begin : g_mon
        logic prev_v = 1'b0;
        always @(negedge clk) begin
            exp_t e;
            if (rv[g] && !prev_v && sb_q[g].size() > 0)
                check($sformatf("u%0d_latency", g), 32'(cyc) - sb_q[g][0].acc, 32'(LAT[g]));
            if (rv[g] && resp_ready) begin
                check($sformatf("u%0d_resp_expected", g), 32'(sb_q[g].size() > 0), 1);
                if (sb_q[g].size() > 0) begin
                    e = sb_q[g].pop_front();
                    check($sformatf("u%0d_rdata", g), rd[g], e.rdata);
                    check($sformatf("u%0d_error", g), 32'(re[g]), 32'(e.err));
                end
            end
            prev_v = rv[g];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_release");

        txn(1'b0, 6'd5, 32'h0, 4'h0);
        txn(1'b1, 6'd10, 32'hDEAD_BEEF, 4'hF);
        txn(1'b0, 6'd10, 32'h0, 4'h0);
        txn(1'b1, 6'd3, 32'hAABB_CCDD, 4'b0101);
        txn(1'b0, 6'd3, 32'h0, 4'h0);
        txn(1'b1, 6'd4, 32'hFFFF_FFFF, 4'b0000);
        txn(1'b0, 6'd4, 32'h0, 4'h0);
        txn(1'b1, 6'd50, 32'h1234_5678, 4'hF);
        txn(1'b0, 6'd50, 32'h0, 4'h0);
        txn(1'b0, 6'd2, 32'h0, 4'h0);
        txn(1'b0, 6'd47, 32'h0, 4'h0);
        txn(1'b0, 6'd48, 32'h0, 4'h0);

        // Response backpressure with request inputs churning.
        resp_ready = 1'b0;
        do_req(1'b0, 6'd10, 32'h0, 4'h0, 1'b1);
        for (int k = 0; k < 40 && !(&rv); k++) @(negedge clk);
        check("hold_all_valid", 32'(&rv), 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom);
            scramble_req();
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                check($sformatf("hold%0d_u%0d_valid", c, g), 32'(rv[g]), 1);
                check($sformatf("hold%0d_u%0d_rdata", c, g), rd[g], mdl[10]);
                check($sformatf("hold%0d_u%0d_req_ready", c, g), 32'(rdy[g]), 0);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        wait_idle();
        txn(1'b0, 6'd10, 32'h0, 4'h0);

        // Reset while every controller sits in WAIT of a write to addr 7.
        do_req(1'b1, 6'd7, 32'h0BAD_F00D, 4'hF, 1'b0);
        @(negedge clk); #1;
        check("midrst_busy", 32'(bsy), 32'(3'b111));
        rst = 1'b1;
        #1;
        for (int g = 0; g < NDUT; g++) sb_q[g].delete();
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        txn(1'b0, 6'd7, 32'h0, 4'h0);
        txn(1'b0, 6'd10, 32'h0, 4'h0);

        repeat (3) @(negedge clk);
        check("final_idle", 32'(bsy), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, multi-cycle data memory with a valid/ready request and response handshake and programmable wait states. It replaces the single-cycle data memory in the MEM stage. The pipeline can now stall on memory latency instead of relying on a combinational read path. Contents are preset to an index pattern on reset so the pipeline tests can load known data without a loader.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 6, word-address width.
- DEPTH, 2**ADDR_W, number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- WAIT_CYCLES, 2, extra wait states per access; range 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte write strobes; used only when DMEM_BYTE_STROBE_EN is defined.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_error  out  1  address ≥ DEPTH.
- busy  out  1  state ≠ IDLE.

## Operation
- Storage is DEPTH words of DATA_W bits.
- The FSM has three states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE). It is a combinational decode of the state only and does not depend on req_valid.
- IDLE → WAIT on req_valid && req_ready:
  - latch write, addr, wdata and wstrb;
  - load wait counter cnt ← WAIT_CYCLES.
- WAIT, cnt ≠ 0: cnt ← cnt − 1.
- WAIT, cnt == 0: perform the access, load the response registers, set resp_valid ← 1, go to RESP.
  - Read, addr < DEPTH: resp_rdata ← mem[addr], resp_error ← 0.
  - Write, addr < DEPTH: update mem[addr], resp_rdata ← 0, resp_error ← 0.
  - addr ≥ DEPTH: no write, resp_rdata ← 0, resp_error ← 1.
- RESP: response registers are held stable while resp_ready = 0.
- RESP → IDLE on resp_ready: resp_valid ← 0; resp_rdata and resp_error ← 0.
- Inputs are sampled only at the accept edge. Changes to req_* while busy have no effect.
- Reset (asynchronous, any state, including mid-transaction):
  - state ← IDLE, cnt ← 0;
  - resp_valid, resp_rdata, resp_error ← 0;
  - mem[i] ← i truncated to DATA_W, for every i;
  - any in-flight write is dropped.
- Reset values of outputs: req_ready = 1, busy = 0, all other outputs 0.

## Timing
- Accept edge T. The access and resp_valid rise occur at edge T + WAIT_CYCLES + 1.
- WAIT_CYCLES = 0 gives resp_valid high one cycle after the accept edge.
- Earliest next accept is the edge after the resp handshake edge. One transaction per WAIT_CYCLES + 3 cycles when resp_ready is tied high.
- A write is visible to a read accepted after its response handshake. No ordering hazard exists because only one transaction is outstanding.
- resp_valid never drops without resp_ready, except on rst.
- No combinational path from any req_* input to any resp_* output.

## Configuration
- DMEM_BYTE_STROBE_EN defined:
  - a write updates only the bytes whose req_wstrb bit is 1;
  - byte k covers bits [8k+7:8k];
  - wstrb = 0 completes normally with no data change.
- DMEM_BYTE_STROBE_EN undefined:
  - req_wstrb is ignored;
  - every write updates the full word.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then read addr 5 (default parameters) → resp_valid at T+3, resp_rdata = 5, resp_error = 0.
- Write 0xDEADBEEF to addr 10, then read addr 10 → write response rdata = 0; read returns 0xDEADBEEF.
- DMEM_BYTE_STROBE_EN, addr 3 holds 3, write 0xAABBCCDD with wstrb = 4'b0101 → read returns 0x00BB00DD. Without the macro → 0xAABBCCDD.
- DEPTH = 48, ADDR_W = 6, write then read addr 50 → resp_error = 1 on both; rdata = 0; mem[50 mod anything] unchanged (spot-check addr 2 = 2).
- Hold resp_ready = 0 for 4 cycles during RESP, toggling req_* throughout → resp_valid/rdata stable, req_ready = 0, no new accept.
- Assert rst in WAIT of a write to addr 7 → outputs return to reset values, next read of addr 7 returns 7. Repeat with WAIT_CYCLES = 0 and 15, checking latency 1 and 16.
